// File: rtl/clkdiv_pkg.sv
// ---------------------------------------------------------------------------
// clkdiv_pkg
// Shared helpers for multi_clock_divider and clkdiv_channel.
//   default_half(in_f, out_f) : reset half-period in input clock cycles,
//                               never smaller than 1.
//   chan_w(n)                 : width of a channel index, at least 1 bit.
//   CH_W                      : channel index width for the default
//                               channel count.
// The half-period type depends on the DIV_WIDTH module parameter, so it is
// declared inside the modules rather than here.
// ---------------------------------------------------------------------------
package clkdiv_pkg;

  localparam int DEF_CHANNELS = 4;

  function automatic int default_half(input int in_f, input int out_f);
    int h;
    if (out_f > 0) begin
      h = in_f / out_f / 2;
    end else begin
      h = 1;
    end
    if (h < 1) begin
      h = 1;
    end
    return h;
  endfunction

  function automatic int chan_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CH_W = chan_w(DEF_CHANNELS);

endpackage

// File: rtl/clkdiv_channel.sv
// ---------------------------------------------------------------------------
// clkdiv_channel
// One divider channel: a counter running 0..half-1, a 50% square wave that
// toggles at each terminal count, and a one-cycle tick on each rising edge.
// A new half-period is written into a shadow register and only becomes
// active at a half-period boundary (or immediately next cycle when the
// channel is disabled), so the output never glitches.
//
// Ports
//   inclk     in   1          clock
//   rst_n     in   1          asynchronous reset, active-low
//   en        in   1          run enable; low holds counter/outclk/tick at 0
//   load      in   1          write load_val into the shadow register
//   load_val  in   DIV_WIDTH  new half-period (0 is stored as 1)
//   sync      in   1          phase realign (tied low when not built in)
//   pending   out  1          shadow value waiting to become active
//   outclk    out  1          divided square wave
//   tick      out  1          high for the cycle in which outclk went 0->1
// ---------------------------------------------------------------------------
module clkdiv_channel #(
  parameter int                   DIV_WIDTH  = 24,
  parameter logic [DIV_WIDTH-1:0] RESET_HALF = DIV_WIDTH'(1)
) (
  input  logic                 inclk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 load,
  input  logic [DIV_WIDTH-1:0] load_val,
  input  logic                 sync,
  output logic                 pending,
  output logic                 outclk,
  output logic                 tick
);

  localparam logic [DIV_WIDTH-1:0] ONE = DIV_WIDTH'(1);

  logic [DIV_WIDTH-1:0] r_cnt;
  logic [DIV_WIDTH-1:0] r_half;
  logic [DIV_WIDTH-1:0] r_shadow;
  logic                 r_pending;
  logic                 r_outclk;
  logic                 r_tick;

  logic                 w_terminal;
  logic [DIV_WIDTH-1:0] w_load_half;

  // Greater-or-equal rather than equal: if the active half ever shrinks
  // below the current count, the next edge still terminates the half-period.
  assign w_terminal  = (r_cnt >= (r_half - ONE));
  assign w_load_half = (load_val == '0) ? ONE : load_val;

  always_ff @(posedge inclk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_half    <= RESET_HALF;
      r_shadow  <= RESET_HALF;
      r_pending <= 1'b0;
      r_outclk  <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      if (!en) begin
        // Disabled: nothing is running, so a pending value can go live now.
        r_cnt    <= '0;
        r_outclk <= 1'b0;
        r_tick   <= 1'b0;
        if (r_pending) begin
          r_half    <= r_shadow;
          r_pending <= 1'b0;
        end
      end else if (sync) begin
        // Realign beats a coinciding terminal count, but that boundary is
        // still a legal point to activate a pending value.
        r_cnt    <= '0;
        r_outclk <= 1'b0;
        r_tick   <= 1'b0;
        if (w_terminal && r_pending) begin
          r_half    <= r_shadow;
          r_pending <= 1'b0;
        end
      end else if (w_terminal) begin
        r_cnt    <= '0;
        r_outclk <= ~r_outclk;
        // Tick marks the 0->1 transition of the registered square wave.
        r_tick   <= ~r_outclk;
        if (r_pending) begin
          r_half    <= r_shadow;
          r_pending <= 1'b0;
        end
      end else begin
        r_cnt  <= r_cnt + ONE;
        r_tick <= 1'b0;
      end

      // Load never coincides with an apply: the top only loads a channel
      // whose pending flag is clear.
      if (load) begin
        r_shadow  <= w_load_half;
        r_pending <= 1'b1;
      end
    end
  end

  assign pending = r_pending;
  assign outclk  = r_outclk;
  assign tick    = r_tick;

endmodule

// File: rtl/multi_clock_divider.sv
// ---------------------------------------------------------------------------
// multi_clock_divider
// CHANNELS independent clock dividers driven from one input clock. Each
// channel produces a 50% square wave with a runtime-programmable
// half-period and a one-cycle tick on every rising edge of that wave.
//
// Optional feature macro: CLKDIV_SYNC_EN
//   defined   : adds the sync input; a high sync realigns every enabled
//               channel (counter, outclk and tick to 0).
//   undefined : no sync port; channels free-run from their own enable.
//
// Ports
//   inclk        in   1          sole clock
//   rst_n        in   1          asynchronous reset, active-low
//   chan_en      in   CHANNELS   per-channel run enable
//   cfg_valid    in   1          configuration request
//   cfg_ready    out  1          configuration accept
//   cfg_channel  in   CH_W       target channel
//   cfg_half     in   DIV_WIDTH  half-period in inclk cycles (0 means 1)
//   outclk       out  CHANNELS   divided square waves
//   tick         out  CHANNELS   one-cycle pulse on each outclk 0->1
//   sync         in   1          phase realign (CLKDIV_SYNC_EN only)
//
// Handshake: a configuration transfer happens in a cycle where cfg_valid
// and cfg_ready are both high at the rising edge of inclk. cfg_ready depends
// only on registered state and cfg_channel, never on cfg_valid. A channel
// index outside the implemented range is always ready and its data dropped.
// ---------------------------------------------------------------------------
module multi_clock_divider
  import clkdiv_pkg::*;
#(
  parameter int IN_FREQUENCY  = 10**7,
  parameter int OUT_FREQUENCY = 100,
  parameter int CHANNELS      = 4,
  parameter int DIV_WIDTH     = 24
) (
  input  logic                         inclk,
  input  logic                         rst_n,
  input  logic [CHANNELS-1:0]          chan_en,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  logic [chan_w(CHANNELS)-1:0]  cfg_channel,
  input  logic [DIV_WIDTH-1:0]         cfg_half,
  output logic [CHANNELS-1:0]          outclk,
  output logic [CHANNELS-1:0]          tick
`ifdef CLKDIV_SYNC_EN
  ,
  input  logic                         sync
`endif
);

  localparam int CW      = chan_w(CHANNELS);
  localparam int PAD_CHS = 1 << CW;
  localparam logic [DIV_WIDTH-1:0] DEFAULT_HALF =
    DIV_WIDTH'(default_half(IN_FREQUENCY, OUT_FREQUENCY));

  logic [CHANNELS-1:0] w_pending;
  logic [CHANNELS-1:0] w_load;
  logic [PAD_CHS-1:0]  w_pend_pad;
  logic                w_xfer;
  logic                w_sync;

`ifdef CLKDIV_SYNC_EN
  assign w_sync = sync;
`else
  assign w_sync = 1'b0;
`endif

  // Pending flags padded out to every encodable channel index. The padding
  // reads as "not pending", which makes out-of-range indices always ready.
  always_comb begin
    w_pend_pad                 = '0;
    w_pend_pad[CHANNELS-1:0]   = w_pending;
  end

  assign cfg_ready = ~w_pend_pad[cfg_channel];
  assign w_xfer    = cfg_valid & cfg_ready;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    assign w_load[gi] = w_xfer && (cfg_channel == CW'(gi));

    clkdiv_channel #(
      .DIV_WIDTH  (DIV_WIDTH),
      .RESET_HALF (DEFAULT_HALF)
    ) u_chan (
      .inclk    (inclk),
      .rst_n    (rst_n),
      .en       (chan_en[gi]),
      .load     (w_load[gi]),
      .load_val (cfg_half),
      .sync     (w_sync),
      .pending  (w_pending[gi]),
      .outclk   (outclk[gi]),
      .tick     (tick[gi])
    );
  end

endmodule

// File: tb/tb_multi_clock_divider.sv
module tb_multi_clock_divider;

  localparam int CH       = 3;
  localparam int DW       = 8;
  localparam int CW       = 2;
  localparam int DEF_HALF = 6;   // 1200 / 100 / 2

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CH-1:0] chan_en = '0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [CW-1:0] cfg_channel = '0;
  logic [DW-1:0] cfg_half = '0;
  logic [CH-1:0] outclk;
  logic [CH-1:0] tick;
`ifdef CLKDIV_SYNC_EN
  logic          sync = 1'b0;
`endif

  always #5 clk = ~clk;

  multi_clock_divider #(
    .IN_FREQUENCY  (1200),
    .OUT_FREQUENCY (100),
    .CHANNELS      (CH),
    .DIV_WIDTH     (DW)
  ) dut (
    .inclk       (clk),
    .rst_n       (rst_n),
    .chan_en     (chan_en),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_channel (cfg_channel),
    .cfg_half    (cfg_half),
    .outclk      (outclk),
    .tick        (tick)
`ifdef CLKDIV_SYNC_EN
    ,
    .sync        (sync)
`endif
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Down-counting model: m_left is the number of enabled edges until the
  // next toggle of outclk.
  int            m_left[CH];
  int            m_half[CH];
  int            m_shadow[CH];
  logic          m_pend[CH];
  logic [CH-1:0] m_out;
  logic [CH-1:0] m_tick;

  logic [2*CH-1:0] exp_q[$];

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_half[i]   = DEF_HALF;
      m_shadow[i] = DEF_HALF;
      m_pend[i]   = 1'b0;
      m_left[i]   = DEF_HALF;
    end
    m_out  = '0;
    m_tick = '0;
  endtask

  function automatic logic exp_ready();
    int c;
    c = int'(cfg_channel);
    if (c >= CH) return 1'b1;
    return !m_pend[c];
  endfunction

  task automatic model_step();
    int   c;
    logic xfer;
    logic s;
    c    = int'(cfg_channel);
    xfer = cfg_valid && exp_ready();
`ifdef CLKDIV_SYNC_EN
    s = sync;
`else
    s = 1'b0;
`endif
    for (int i = 0; i < CH; i++) begin
      if (!chan_en[i]) begin
        m_out[i]  = 1'b0;
        m_tick[i] = 1'b0;
        if (m_pend[i]) begin
          m_half[i] = m_shadow[i];
          m_pend[i] = 1'b0;
        end
        m_left[i] = m_half[i];
      end else if (s) begin
        if (m_left[i] == 1 && m_pend[i]) begin
          m_half[i] = m_shadow[i];
          m_pend[i] = 1'b0;
        end
        m_out[i]  = 1'b0;
        m_tick[i] = 1'b0;
        m_left[i] = m_half[i];
      end else begin
        m_left[i] = m_left[i] - 1;
        if (m_left[i] == 0) begin
          m_out[i]  = ~m_out[i];
          m_tick[i] = m_out[i];
          if (m_pend[i]) begin
            m_half[i] = m_shadow[i];
            m_pend[i] = 1'b0;
          end
          m_left[i] = m_half[i];
        end else begin
          m_tick[i] = 1'b0;
        end
      end
    end
    if (xfer && c < CH) begin
      m_shadow[c] = (cfg_half == '0) ? 1 : int'(cfg_half);
      m_pend[c]   = 1'b1;
    end
  endtask

  // One clock: model advances on the rising edge and pushes its expectation;
  // the DUT is sampled on the falling edge against the popped entry.
  task automatic cycle();
    logic [2*CH-1:0] e;
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    exp_q.push_back({m_out, m_tick});
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check_eq("queue_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check_eq("outclk", 32'(outclk), 32'(e[2*CH-1:CH]));
      check_eq("tick", 32'(tick), 32'(e[CH-1:0]));
    end
    check_eq("cfg_ready", 32'(cfg_ready), 32'(exp_ready()));
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  // ---------------- driver tasks ----------------
  task automatic cfg_write(input int c, input int v);
    cfg_channel = CW'(c);
    cfg_half    = DW'(v);
    cfg_valid   = 1'b1;
    cycle();
    cfg_valid   = 1'b0;
  endtask

  task automatic count_ticks(input int idx, input int n, output int cnt);
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      cycle();
      if (tick[idx]) cnt++;
    end
  endtask

  task automatic cycles_to_rise(input int idx, output int cnt);
    cnt = 0;
    do begin
      cycle();
      cnt++;
    end while (!outclk[idx] && cnt < 40);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    model_reset();

    // Reset state
    run(3);
    check_eq("reset_outclk", 32'(outclk), 32'd0);
    check_eq("reset_tick", 32'(tick), 32'd0);
    check_eq("reset_ready", 32'(cfg_ready), 32'd1);

    // Release with all channels enabled: first rise at edge 6
    rst_n   = 1'b1;
    chan_en = '1;
    run(5);
    check_eq("pre_rise_outclk", 32'(outclk), 32'd0);
    cycle();
    check_eq("first_rise_outclk", 32'(outclk), 32'h7);
    check_eq("first_rise_tick", 32'(tick), 32'h7);
    run(2);

    // Reprogram ch0 mid-period (counter at 2)
    cfg_write(0, 3);
    check_eq("ch0_pending", 32'(cfg_ready), 32'd0);
    cfg_channel = 2'd0;
    cfg_half    = 8'd9;
    cfg_valid   = 1'b1;
    #1;
    check_eq("ch0_busy_ready", 32'(cfg_ready), 32'd0);
    cycle();
    cfg_channel = 2'd1;
    cfg_half    = 8'd4;
    #1;
    check_eq("ch1_ready", 32'(cfg_ready), 32'd1);
    cycle();
    cfg_valid = 1'b0;
    run(30);
    count_ticks(0, 24, n);
    check_eq("ch0_ticks_half3", n, 32'd4);
    count_ticks(1, 24, n);
    check_eq("ch1_ticks_half4", n, 32'd3);

    // Zero half-period on ch2 behaves as half=1
    cfg_write(2, 0);
    run(10);
    count_ticks(2, 10, n);
    check_eq("ch2_ticks_half1", n, 32'd5);

    // Disable ch1 while its outclk is high
    n = 0;
    while (!outclk[1] && n < 20) begin
      cycle();
      n++;
    end
    check_eq("ch1_wait_high", 32'(outclk[1]), 32'd1);
    chan_en[1] = 1'b0;
    cycle();
    check_eq("ch1_drop_outclk", 32'(outclk[1]), 32'd0);
    check_eq("ch1_drop_tick", 32'(tick[1]), 32'd0);
    run(3);
    chan_en[1] = 1'b1;
    cycles_to_rise(1, n);
    check_eq("ch1_reenable_rise", n, 32'd4);

    // Configure a disabled channel: applied the next cycle
    run(3);
    chan_en[1] = 1'b0;
    cycle();
    cfg_write(1, 2);
    check_eq("ch1_dis_pending", 32'(cfg_ready), 32'd0);
    cycle();
    check_eq("ch1_dis_applied", 32'(cfg_ready), 32'd1);
    chan_en[1] = 1'b1;
    cycles_to_rise(1, n);
    check_eq("ch1_new_half_rise", n, 32'd2);

    // Out-of-range channel index: accepted and discarded
    cfg_channel = 2'd3;
    cfg_half    = 8'd1;
    cfg_valid   = 1'b1;
    #1;
    check_eq("oob_ready", 32'(cfg_ready), 32'd1);
    cycle();
    cfg_valid = 1'b0;
    count_ticks(0, 12, n);
    check_eq("ch0_ticks_after_oob", n, 32'd2);

`ifdef CLKDIV_SYNC_EN
    // Realign ch0 (half 3) and ch1 (half 5)
    cfg_write(1, 5);
    run(12);
    sync = 1'b1;
    cycle();
    sync = 1'b0;
    check_eq("sync_outclk", 32'(outclk[1:0]), 32'd0);
    cycles_to_rise(0, n);
    check_eq("sync_ch0_rise", n, 32'd3);
    run(4);
`endif

    // Asynchronous reset mid-run
    run(3);
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_outclk", 32'(outclk), 32'd0);
    check_eq("async_rst_tick", 32'(tick), 32'd0);
    check_eq("async_rst_ready", 32'(cfg_ready), 32'd1);
    run(2);
    rst_n = 1'b1;
    cycles_to_rise(0, n);
    check_eq("post_rst_rise", n, 32'd6);
    run(14);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
